// File: rtl/fluxo_dados_jogo_pkg.sv
// Shared definitions for the memory-game datapath: default widths, last
// sequence address and the fixed sequence ROM contents.
package fluxo_dados_jogo_pkg;

  localparam int DATA_W    = 4;
  localparam int ADDR_W    = 4;
  localparam int LAST_ADDR = 15;

  // Sequence ROM, one-hot button codes; element [15] written first so that
  // address 0 holds 1, address 1 holds 2, ... address 15 holds 4.
  localparam logic [15:0][3:0] ROM_TABLE = {
    4'h4, 4'h1, 4'h8, 4'h8, 4'h4, 4'h4, 4'h2, 4'h2,
    4'h1, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1
  };

  function automatic logic [3:0] rom_read(input logic [3:0] addr);
    return ROM_TABLE[addr];
  endfunction

endpackage

// File: rtl/fluxo_dados_jogo_if.sv
// Command/status bundle between the game control unit (master) and the
// datapath (slave), plus the debug taps driven by the datapath.
interface fluxo_dados_jogo_if
  import fluxo_dados_jogo_pkg::*;
#(
  parameter int DATA_W = fluxo_dados_jogo_pkg::DATA_W,
  parameter int ADDR_W = fluxo_dados_jogo_pkg::ADDR_W
);
  logic              zeraC;
  logic              contaC;
  logic              zeraR;
  logic              registraR;
  logic [DATA_W-1:0] botoes;
  logic              fimC;
  logic              igual;
  logic              jogada;
  logic [ADDR_W-1:0] db_contagem;
  logic [DATA_W-1:0] db_memoria;
  logic [DATA_W-1:0] db_jogada;
  logic              db_tem_jogada;

  modport master (
    output zeraC, contaC, zeraR, registraR, botoes,
    input  fimC, igual, jogada, db_contagem, db_memoria, db_jogada, db_tem_jogada
  );

  modport slave (
    input  zeraC, contaC, zeraR, registraR, botoes,
    output fimC, igual, jogada, db_contagem, db_memoria, db_jogada, db_tem_jogada
  );
endinterface

// File: rtl/fluxo_dados_jogo_detector_jogada.sv
// Button-press detector: two-flop synchroniser for the raw buttons and a
// one-cycle pulse on each transition from "no button" to "some button".
module detector_jogada
  import fluxo_dados_jogo_pkg::*;
#(
  parameter int DATA_W = fluxo_dados_jogo_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] botoes,
  output logic [DATA_W-1:0] sync,
  output logic              tem_jogada,
  output logic              jogada
);
  logic [DATA_W-1:0] s1;
  logic [DATA_W-1:0] s2;
  logic              prev;

  // Synchronise the asynchronous buttons and remember last cycle's activity
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1   <= '0;
      s2   <= '0;
      prev <= 1'b0;
    end else begin
      s1   <= botoes;
      s2   <= s1;
      prev <= |s2;
    end
  end

  // Code changes while held keep |s2 high, so only a 0 -> nonzero edge pulses
  assign sync       = s2;
  assign tem_jogada = |s2;
  assign jogada     = (|s2) & ~prev;
endmodule

// File: rtl/fluxo_dados_jogo.sv
// Memory-game datapath: address counter, fixed sequence ROM, move register,
// comparator and button-press detector. Outputs depend only on flops.
module fluxo_dados_jogo
  import fluxo_dados_jogo_pkg::*;
#(
  parameter int DATA_W    = fluxo_dados_jogo_pkg::DATA_W,
  parameter int ADDR_W    = fluxo_dados_jogo_pkg::ADDR_W,
  parameter int LAST_ADDR = fluxo_dados_jogo_pkg::LAST_ADDR
) (
  input  logic            clock,
  input  logic            reset_n,
  fluxo_dados_jogo_if.slave bus
);
  logic [ADDR_W-1:0] contagem;
  logic [DATA_W-1:0] jogada_reg;
  logic [DATA_W-1:0] memoria;
  logic [DATA_W-1:0] botoes_sync;
  logic              tem_jogada;
  logic              pulso;

  detector_jogada #(.DATA_W(DATA_W)) u_detector (
    .clock      (clock),
    .reset_n    (reset_n),
    .botoes     (bus.botoes),
    .sync       (botoes_sync),
    .tem_jogada (tem_jogada),
    .jogada     (pulso)
  );

  // Address counter: clear beats count; wraps after the last address
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      contagem <= '0;
    end else if (bus.zeraC) begin
      contagem <= '0;
    end else if (bus.contaC) begin
      if (contagem == ADDR_W'(LAST_ADDR)) contagem <= '0;
      else                                contagem <= contagem + 1'b1;
    end
  end

  // Move register: clear beats load; loads the synchronised code unmodified
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      jogada_reg <= '0;
    end else if (bus.zeraR) begin
      jogada_reg <= '0;
    end else if (bus.registraR) begin
      jogada_reg <= botoes_sync;
    end
  end

  assign memoria = DATA_W'(rom_read(4'(contagem)));

  assign bus.fimC          = (contagem == ADDR_W'(LAST_ADDR));
  assign bus.igual         = (memoria == jogada_reg);
  assign bus.jogada        = pulso;
  assign bus.db_contagem   = contagem;
  assign bus.db_memoria    = memoria;
  assign bus.db_jogada     = jogada_reg;
  assign bus.db_tem_jogada = tem_jogada;
endmodule

// File: tb/tb_fluxo_dados_jogo.sv
// Directed bench for the memory-game datapath.
module tb_fluxo_dados_jogo;
  logic clock;
  logic reset_n;
  int   passed;
  int   total;
  int   pulses;

  fluxo_dados_jogo_if bus ();

  fluxo_dados_jogo dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset_n       = 1'b0;
    bus.zeraC     = 1'b0;
    bus.contaC    = 1'b0;
    bus.zeraR     = 1'b0;
    bus.registraR = 1'b0;
    bus.botoes    = 4'h0;
    #3;
    // reset state
    check("rst_cnt",   32'(bus.db_contagem),   32'd0);
    check("rst_jog",   32'(bus.jogada),        32'd0);
    check("rst_tem",   32'(bus.db_tem_jogada), 32'd0);
    check("rst_fim",   32'(bus.fimC),          32'd0);
    check("rst_mem",   32'(bus.db_memoria),    32'd1);
    check("rst_igual", 32'(bus.igual),         32'd0);
    check("rst_reg",   32'(bus.db_jogada),     32'd0);
    tick();
    reset_n = 1'b1;

    // 1: count to 5 with a press landing on the 5th edge, then async reset
    bus.contaC = 1'b1;
    tick(); tick(); tick();
    bus.botoes = 4'h1;
    tick();
    check("t1_jog_early", 32'(bus.jogada), 32'd0);
    tick();
    check("t1_cnt5", 32'(bus.db_contagem), 32'd5);
    check("t1_mem5", 32'(bus.db_memoria),  32'd2);
    check("t1_jog",  32'(bus.jogada),      32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t1_rst_cnt", 32'(bus.db_contagem),   32'd0);
    check("t1_rst_jog", 32'(bus.jogada),        32'd0);
    check("t1_rst_tem", 32'(bus.db_tem_jogada), 32'd0);
    bus.botoes = 4'h0;
    bus.contaC = 1'b0;
    #1 reset_n = 1'b1;
    tick(); tick();
    check("t1_no_pulse", 32'(bus.jogada), 32'd0);

    // 2: count through the last address and wrap; simultaneous clear/count
    bus.contaC = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    check("t2_cnt14", 32'(bus.db_contagem), 32'd14);
    check("t2_fim14", 32'(bus.fimC),        32'd0);
    tick();
    check("t2_cnt15", 32'(bus.db_contagem), 32'd15);
    check("t2_fim15", 32'(bus.fimC),        32'd1);
    check("t2_mem15", 32'(bus.db_memoria),  32'd4);
    tick();
    check("t2_wrap",     32'(bus.db_contagem), 32'd0);
    check("t2_fim_wrap", 32'(bus.fimC),        32'd0);
    tick(); tick(); tick();
    check("t2_cnt3", 32'(bus.db_contagem), 32'd3);
    check("t2_mem3", 32'(bus.db_memoria),  32'd8);
    bus.zeraC = 1'b1;
    tick();
    check("t2_zera_conta", 32'(bus.db_contagem), 32'd0);
    bus.zeraC  = 1'b0;
    bus.contaC = 1'b0;

    // 3: held press gives one pulse; release and re-press gives another
    bus.botoes = 4'h2;
    tick();
    check("t3_e1", 32'(bus.jogada), 32'd0);
    tick();
    check("t3_e2",  32'(bus.jogada),        32'd1);
    check("t3_tem", 32'(bus.db_tem_jogada), 32'd1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.jogada) pulses++;
    end
    check("t3_held", 32'(pulses), 32'd0);
    bus.botoes = 4'h0;
    tick(); tick(); tick();
    check("t3_rel_tem", 32'(bus.db_tem_jogada), 32'd0);
    check("t3_rel_jog", 32'(bus.jogada),        32'd0);
    bus.botoes = 4'h2;
    tick();
    check("t3_re_e1", 32'(bus.jogada), 32'd0);
    tick();
    check("t3_re_e2", 32'(bus.jogada), 32'd1);
    // code change without passing through zero: no pulse
    bus.botoes = 4'h4;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.jogada) pulses++;
    end
    check("t3_change", 32'(pulses), 32'd0);

    // 4: register a move and compare with ROM[0]
    bus.botoes = 4'h1;
    tick(); tick();
    bus.registraR = 1'b1;
    tick();
    bus.registraR = 1'b0;
    check("t4_reg1",   32'(bus.db_jogada), 32'd1);
    check("t4_igual1", 32'(bus.igual),     32'd1);
    bus.botoes = 4'h2;
    tick(); tick();
    bus.registraR = 1'b1;
    tick();
    bus.registraR = 1'b0;
    check("t4_reg2",   32'(bus.db_jogada),  32'd2);
    check("t4_igual2", 32'(bus.igual),      32'd0);
    check("t4_mem0",   32'(bus.db_memoria), 32'd1);
    bus.contaC = 1'b1;
    tick();
    bus.contaC = 1'b0;
    check("t4_igual_a1", 32'(bus.igual), 32'd1);

    // 5: clear wins over load
    bus.botoes = 4'h8;
    tick(); tick();
    bus.zeraR     = 1'b1;
    bus.registraR = 1'b1;
    tick();
    bus.zeraR     = 1'b0;
    bus.registraR = 1'b0;
    check("t5_zeraR", 32'(bus.db_jogada), 32'd0);

    // 6: multi-button press: one pulse, loads unmodified, never matches
    bus.botoes = 4'h0;
    tick(); tick(); tick();
    bus.botoes = 4'h3;
    tick();
    check("t6_e1", 32'(bus.jogada), 32'd0);
    tick();
    check("t6_e2", 32'(bus.jogada), 32'd1);
    tick();
    check("t6_e3", 32'(bus.jogada), 32'd0);
    bus.registraR = 1'b1;
    tick();
    bus.registraR = 1'b0;
    check("t6_reg3", 32'(bus.db_jogada), 32'd3);
    bus.contaC = 1'b1;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus.igual) pulses++;
      tick();
    end
    bus.contaC = 1'b0;
    check("t6_never_igual", 32'(pulses), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
